// File: rtl/p405s_icu_pkg.sv
// Shared ICU fetch definitions: va1 state encoding, reset vector and fetch granule.
package p405s_icu_pkg;

    typedef enum logic [1:0] {
        BOOT      = 2'b00,
        RUN       = 2'b01,
        MISS_WAIT = 2'b10
    } icu_state_e;

    localparam int unsigned ADDR_W            = 32;
    localparam logic [0:31] RESET_VEC_DEFAULT = 32'hFFFF_FFFC;
    localparam int unsigned FETCH_GRAN        = 8;

endpackage

// File: rtl/p405s_icu_seq_inc.sv
// Doubleword incrementer: aligns down to the fetch granule and steps one granule.
module p405s_icu_seq_inc
    import p405s_icu_pkg::*;
(
    input  logic [0:ADDR_W-1] addr,
    output logic [0:ADDR_W-1] next_addr
);

    localparam int unsigned OFS_W = $clog2(FETCH_GRAN);
    localparam int unsigned DW_W  = ADDR_W - OFS_W;

    // Carry out of the top bit is dropped, so the last doubleword wraps to zero.
    assign next_addr = {DW_W'(addr[0:DW_W-1] + DW_W'(1)), OFS_W'(0)};

endmodule

// File: rtl/p405s_icu_fetch_addr_gen.sv
// Va1-stage fetch address generator: sequential advance, redirect, stall hold,
// miss capture and replay, plus a saturating miss counter.
module p405s_icu_fetch_addr_gen
    import p405s_icu_pkg::*;
#(
    parameter logic [0:31] RESET_VEC = RESET_VEC_DEFAULT,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             CB,
    input  logic             RESET_N,
    input  logic             redirValid,
    input  logic [0:31]      redirAddr,
    input  logic             stall,
    input  logic             missInd,
    input  logic [0:31]      va2Addr,
    input  logic             fillDone,
    output logic [0:31]      icuVa1,
    output logic             icuVa1Valid,
    output logic             va2E1,
    output logic             missPending,
    output logic [CNT_W-1:0] missCnt
);

    icu_state_e       state_q, state_d;
    logic [0:31]      va_q, va_d;
    logic             va_vld_q, va_vld_d;
    logic [0:31]      miss_addr_q, miss_addr_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [0:31]      va_seq;
    logic [0:31]      tgt;
    logic             unused_redir_lsb;

    p405s_icu_seq_inc u_seq (
        .addr      (va_q),
        .next_addr (va_seq)
    );

    // Redirect targets are word aligned; the low two bits are dropped.
    assign tgt              = {redirAddr[0:29], 2'b00};
    assign unused_redir_lsb = ^redirAddr[30:31];

    always_ff @(posedge CB or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= BOOT;
            va_q        <= RESET_VEC;
            va_vld_q    <= 1'b0;
            miss_addr_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            va_q        <= va_d;
            va_vld_q    <= va_vld_d;
            miss_addr_q <= miss_addr_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        va_d        = va_q;
        va_vld_d    = va_vld_q;
        miss_addr_d = miss_addr_q;
        miss_cnt_d  = miss_cnt_q;
        unique case (state_q)
            BOOT: begin
                va_d     = redirValid ? tgt : RESET_VEC;
                va_vld_d = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                if (redirValid) begin
                    va_d     = tgt;
                    va_vld_d = 1'b1;
                end else if (missInd) begin
                    miss_addr_d = va2Addr;
                    va_vld_d    = 1'b0;
                    state_d     = MISS_WAIT;
                    if (miss_cnt_q != {CNT_W{1'b1}}) begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                end else if (!stall && va_vld_q) begin
                    va_d = va_seq;
                end
            end
            MISS_WAIT: begin
                // A fill arriving with a redirect is dropped; the redirect wins.
                if (redirValid) begin
                    va_d     = tgt;
                    va_vld_d = 1'b1;
                    state_d  = RUN;
                end else if (fillDone) begin
                    va_d     = miss_addr_q;
                    va_vld_d = 1'b1;
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign icuVa1      = va_q;
    assign icuVa1Valid = va_vld_q;
    assign missPending = (state_q == MISS_WAIT);
    assign missCnt     = miss_cnt_q;
    assign va2E1       = va_vld_q & ~stall & ~missInd & ~redirValid & (state_q != MISS_WAIT);

endmodule

// File: tb/tb_p405s_icu_fetch_addr_gen.sv
// Scoreboard bench for the va1 fetch address generator with directed vectors.
module tb_p405s_icu_fetch_addr_gen;

    logic        CB = 1'b0;
    logic        RESET_N;
    logic        redirValid;
    logic [0:31] redirAddr;
    logic        stall;
    logic        missInd;
    logic [0:31] va2Addr;
    logic        fillDone;
    logic [0:31] icuVa1;
    logic        icuVa1Valid;
    logic        va2E1;
    logic        missPending;
    logic [1:0]  missCnt;

    typedef struct {
        string       nm;
        logic [0:31] va;
        logic        vld;
        logic        e1;
        logic        pend;
        logic [1:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    p405s_icu_fetch_addr_gen #(
        .RESET_VEC (32'hFFFF_FFFC),
        .CNT_W     (2)
    ) dut (
        .CB          (CB),
        .RESET_N     (RESET_N),
        .redirValid  (redirValid),
        .redirAddr   (redirAddr),
        .stall       (stall),
        .missInd     (missInd),
        .va2Addr     (va2Addr),
        .fillDone    (fillDone),
        .icuVa1      (icuVa1),
        .icuVa1Valid (icuVa1Valid),
        .va2E1       (va2E1),
        .missPending (missPending),
        .missCnt     (missCnt)
    );

    always #5 CB = ~CB;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge CB) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.nm, "icuVa1",      icuVa1,              e.va);
            chk(e.nm, "icuVa1Valid", 32'(icuVa1Valid),    32'(e.vld));
            chk(e.nm, "va2E1",       32'(va2E1),          32'(e.e1));
            chk(e.nm, "missPending", 32'(missPending),    32'(e.pend));
            chk(e.nm, "missCnt",     32'(missCnt),        32'(e.cnt));
        end
    end

    // Drive one cycle of inputs, queue the outputs expected during that cycle.
    task automatic step(input logic rst, input logic rv, input logic [0:31] ra, input logic st,
                        input logic mi, input logic [0:31] v2, input logic fd,
                        input logic [0:31] ev, input logic evld, input logic ee1,
                        input logic epd, input logic [1:0] ec, input string nm);
        exp_t e;
        RESET_N    = rst;
        redirValid = rv;
        redirAddr  = ra;
        stall      = st;
        missInd    = mi;
        va2Addr    = v2;
        fillDone   = fd;
        e.nm = nm; e.va = ev; e.vld = evld; e.e1 = ee1; e.pend = epd; e.cnt = ec;
        sb.push_back(e);
        @(posedge CB);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        RESET_N = 1'b0; redirValid = 1'b0; redirAddr = '0; stall = 1'b0;
        missInd = 1'b0; va2Addr = '0; fillDone = 1'b0;
        repeat (2) @(posedge CB);
        #1;
        //    rst rv ra            st mi va2           fd  exp va        vld e1 pd cnt
        step(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hFFFF_FFFC, 0, 0, 0, 2'd0, "rst");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'hFFFF_FFFC, 0, 0, 0, 2'd0, "boot");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'hFFFF_FFFC, 1, 1, 0, 2'd0, "seq0");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_0000, 1, 1, 0, 2'd0, "seq1");
        step(1, 1, 32'h1000,     0, 0, 32'h0,        0, 32'h0000_0008, 1, 0, 0, 2'd0, "redir1000");
        step(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0000_1000, 1, 0, 0, 2'd0, "stall1");
        step(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0000_1000, 1, 0, 0, 2'd0, "stall2");
        step(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0000_1000, 1, 0, 0, 2'd0, "stall3");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_1000, 1, 1, 0, 2'd0, "unstall");
        step(1, 1, 32'h2006,     1, 0, 32'h0,        0, 32'h0000_1008, 1, 0, 0, 2'd0, "redir_stall");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_2004, 1, 1, 0, 2'd0, "tgt2004");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_2008, 1, 1, 0, 2'd0, "seq2008");
        step(1, 0, 32'h0,        0, 1, 32'h3010,     0, 32'h0000_2010, 1, 0, 0, 2'd0, "miss3010");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_2010, 0, 0, 1, 2'd1, "mw1");
        step(1, 0, 32'h0,        0, 1, 32'h7777_0000, 0, 32'h0000_2010, 0, 0, 1, 2'd1, "mw2_miss_ign");
        step(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0000_2010, 0, 0, 1, 2'd1, "mw3_stall_ign");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_2010, 0, 0, 1, 2'd1, "mw4");
        step(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_2010, 0, 0, 1, 2'd1, "fill");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_3010, 1, 1, 0, 2'd1, "replay3010");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_3018, 1, 1, 0, 2'd1, "seq3018");
        step(1, 0, 32'h0,        0, 1, 32'h3018,     0, 32'h0000_3020, 1, 0, 0, 2'd1, "miss3018");
        step(1, 1, 32'h4000,     0, 0, 32'h0,        1, 32'h0000_3020, 0, 0, 1, 2'd2, "fill_redir");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_4000, 1, 1, 0, 2'd2, "tgt4000");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_4008, 1, 1, 0, 2'd2, "no_replay");
        step(1, 0, 32'h0,        1, 1, 32'h4008,     0, 32'h0000_4010, 1, 0, 0, 2'd2, "miss_beats_stall");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_4010, 0, 0, 1, 2'd3, "mw_cnt3");
        step(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_4010, 0, 0, 1, 2'd3, "fill2");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_4008, 1, 1, 0, 2'd3, "replay4008");
        step(1, 0, 32'h0,        0, 1, 32'h5000,     0, 32'h0000_4010, 1, 0, 0, 2'd3, "miss4");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_4010, 0, 0, 1, 2'd3, "cnt_sat");
        step(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hFFFF_FFFC, 0, 0, 0, 2'd0, "rst_mid_miss");
        step(0, 1, 32'h9000,     0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 0, 0, 2'd0, "rst_hold");
        step(1, 1, 32'h6001,     0, 0, 32'h0,        0, 32'hFFFF_FFFC, 0, 0, 0, 2'd0, "boot_redir");
        step(1, 1, 32'hFFFF_FFF8, 0, 0, 32'h0,       0, 32'h0000_6000, 1, 0, 0, 2'd0, "tgt6000");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'hFFFF_FFF8, 1, 1, 0, 2'd0, "top_dw");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_0000, 1, 1, 0, 2'd0, "wrap");
        step(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_0008, 1, 1, 0, 2'd0, "after_wrap");
        @(negedge CB);
        #1;
        chk("end", "sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
